// File: rtl/uart_pkg.sv
// Shared types and helpers for the 8N1 UART transmitter.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_e;

  localparam int unsigned DATA_BITS = 8;

  function automatic int unsigned clks_per_bit(input int unsigned clk_hz,
                                               input int unsigned baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_if.sv
// Bundle of the host-side UART transmit signals, clocked by clk with active-low rst.
interface uart_if
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ = 100_000_000,
  parameter int unsigned BAUD   = 9600
) (
  input logic clk,
  input logic rst
);

  localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD);

  logic                 tx_start;
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_busy;
  logic                 txd;

  modport host (
    input  clk, rst, tx_busy, txd,
    output tx_start, tx_data
  );

  modport dut (
    input  clk, rst, tx_start, tx_data,
    output tx_busy, txd
  );

endinterface

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while enabled, pulses bit_done on the last count.
module uart_baud_cnt #(
  parameter int unsigned CLKS_PER_BIT = 10416
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic bit_done
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q;

  assign bit_done = enable && (cnt_q == CNT_MAX);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (enable) begin
      if (cnt_q == CNT_MAX) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_8n1.sv
// 8N1 UART transmitter: one start bit, eight data bits LSB first, one stop bit.
module uart_tx_8n1
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ = 100_000_000,
  parameter int unsigned BAUD   = 9600
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tx_start,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_busy,
  output logic                 txd
);

  localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD);
  localparam int unsigned IDX_W        = $clog2(DATA_BITS);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  if (CLKS_PER_BIT < 2) begin : g_bad_baud
    $error("uart_tx_8n1: CLK_HZ/BAUD must be at least 2");
  end

  tx_state_e            state_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [IDX_W-1:0]     bit_idx_q;
  logic                 accept;
  logic                 bit_done;

  assign accept = (state_q == IDLE) && tx_start;

  uart_baud_cnt #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud_cnt (
    .clk      (clk),
    .rst      (rst),
    .clear    (accept),
    .enable   (state_q != IDLE),
    .bit_done (bit_done)
  );

  // txd and tx_busy are updated on the same edge as the state so they stay glitch-free.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_idx_q <= '0;
      txd       <= 1'b1;
      tx_busy   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (tx_start) begin
            shift_q   <= tx_data;
            bit_idx_q <= '0;
            txd       <= 1'b0;
            tx_busy   <= 1'b1;
            state_q   <= START;
          end
        end
        START: begin
          if (bit_done) begin
            txd     <= shift_q[0];
            state_q <= DATA;
          end
        end
        DATA: begin
          if (bit_done) begin
            if (bit_idx_q == IDX_LAST) begin
              txd     <= 1'b1;
              state_q <= STOP;
            end else begin
              bit_idx_q <= bit_idx_q + 1'b1;
              txd       <= shift_q[bit_idx_q + 1'b1];
            end
          end
        end
        STOP: begin
          if (bit_done) begin
            tx_busy <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_8n1.sv
// Directed and back-to-back bench for uart_tx_8n1 at a reduced bit period.
module tb_uart_tx_8n1;

  localparam int unsigned CLK_HZ = 1_000_000;
  localparam int unsigned BAUD   = 250_000;
  localparam int unsigned CPB    = uart_pkg::clks_per_bit(CLK_HZ, BAUD);
  localparam int unsigned LIMIT  = 40 * CPB;
  localparam int unsigned NBYTES = 512;

  logic clk;
  logic rst;

  int n_checks;
  int n_fail;

  logic [7:0] bytes [NBYTES];

  uart_if #(
    .CLK_HZ (CLK_HZ),
    .BAUD   (BAUD)
  ) bus (
    .clk (clk),
    .rst (rst)
  );

  uart_tx_8n1 #(
    .CLK_HZ (CLK_HZ),
    .BAUD   (BAUD)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .tx_start (bus.tx_start),
    .tx_data  (bus.tx_data),
    .tx_busy  (bus.tx_busy),
    .txd      (bus.txd)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch one frame from IDLE and check every bit level, its duration and tx_busy.
  // With inject set, a competing request for 8'hA3 is raised mid-frame.
  task automatic send_frame(input logic [7:0] b, input bit inject);
    logic [9:0] exp_bits;
    int         lvl_cnt;
    int         busy_cnt;
    exp_bits = {1'b1, b, 1'b0};
    busy_cnt = 0;
    bus.tx_data  = b;
    bus.tx_start = 1'b1;
    tick();
    bus.tx_start = 1'b0;
    bus.tx_data  = ~b;
    check_eq("busy_after_accept", {31'd0, bus.tx_busy}, 32'd1);
    for (int k = 0; k < 10; k++) begin
      lvl_cnt = 0;
      for (int c = 0; c < int'(CPB); c++) begin
        if (inject && k == 4 && c == 0) begin
          bus.tx_start = 1'b1;
          bus.tx_data  = 8'hA3;
        end
        if (inject && k == 6 && c == 0) bus.tx_start = 1'b0;
        if (bus.txd === exp_bits[k]) lvl_cnt++;
        if (bus.tx_busy === 1'b1) busy_cnt++;
        tick();
      end
      check_eq($sformatf("bit%0d_of_%02h", k, b), lvl_cnt, CPB);
    end
    check_eq("busy_len", busy_cnt, 10 * CPB);
    check_eq("busy_end", {31'd0, bus.tx_busy}, 32'd0);
    check_eq("txd_end", {31'd0, bus.txd}, 32'd1);
  endtask

  task automatic idle_check(input string tag, input int cycles);
    int bad;
    bad = 0;
    for (int i = 0; i < cycles; i++) begin
      if (bus.txd !== 1'b1 || bus.tx_busy !== 1'b0) bad++;
      tick();
    end
    check_eq(tag, bad, 0);
  endtask

  task automatic drive_stream();
    int n;
    bus.tx_start = 1'b1;
    for (int i = 0; i < int'(NBYTES); i++) begin
      bus.tx_data = bytes[i];
      n = 0;
      while (bus.tx_busy !== 1'b1 && n < int'(LIMIT)) begin
        tick();
        n++;
      end
      if (n >= int'(LIMIT)) check_eq("drv_busy_rise", n, 0);
      n = 0;
      while (bus.tx_busy !== 1'b0 && n < int'(LIMIT)) begin
        tick();
        n++;
      end
      if (n >= int'(LIMIT)) check_eq("drv_busy_fall", n, 0);
    end
    bus.tx_start = 1'b0;
  endtask

  task automatic monitor_stream();
    int         n;
    logic [9:0] fr;
    for (int j = 0; j < int'(NBYTES); j++) begin
      n = 0;
      while (bus.txd !== 1'b0 && n < int'(LIMIT)) begin
        tick();
        n++;
      end
      check_eq("mon_start_seen", {31'd0, n < int'(LIMIT)}, 32'd1);
      if (n >= int'(LIMIT)) break;
      repeat (CPB / 2) tick();
      fr[0] = bus.txd;
      for (int b = 1; b < 10; b++) begin
        repeat (CPB) tick();
        fr[b] = bus.txd;
      end
      check_eq($sformatf("rx_frame%0d", j), {22'd0, fr}, {22'd0, 1'b1, bytes[j], 1'b0});
      if (j < int'(NBYTES) - 1) begin
        n = 0;
        while (bus.txd === 1'b1 && n < int'(LIMIT)) begin
          tick();
          n++;
        end
        // Samples still high from mid-stop through the single idle cycle.
        check_eq("gap_len", n, CPB - CPB / 2 + 1);
      end
    end
  endtask

  initial begin
    n_checks     = 0;
    n_fail       = 0;
    bus.tx_start = 1'b0;
    bus.tx_data  = 8'h00;
    rst          = 1'b1;
    for (int i = 0; i < int'(NBYTES); i++) bytes[i] = 8'($urandom);

    // Reset asserted between clock edges must take effect at once.
    #2 rst = 1'b0;
    #1;
    check_eq("rst_txd", {31'd0, bus.txd}, 32'd1);
    check_eq("rst_busy", {31'd0, bus.tx_busy}, 32'd0);
    tick();
    idle_check("rst_hold", 5);
    rst = 1'b1;
    idle_check("post_rst_idle", 4 * CPB);

    send_frame(8'h55, 1'b0);
    idle_check("idle_after_55", 3);
    send_frame(8'h00, 1'b0);
    send_frame(8'hFF, 1'b0);
    idle_check("idle_after_ff", 3);

    send_frame(8'h3C, 1'b1);
    idle_check("no_a3_frame", 3 * CPB);

    // Reset during data bit 4 of 8'hF0.
    bus.tx_data  = 8'hF0;
    bus.tx_start = 1'b1;
    tick();
    bus.tx_start = 1'b0;
    repeat (5 * CPB + 1) tick();
    check_eq("f0_bit4_txd", {31'd0, bus.txd}, 32'd1);
    check_eq("f0_bit4_busy", {31'd0, bus.tx_busy}, 32'd1);
    rst = 1'b0;
    #1;
    check_eq("abort_txd", {31'd0, bus.txd}, 32'd1);
    check_eq("abort_busy", {31'd0, bus.tx_busy}, 32'd0);
    tick();
    tick();
    rst = 1'b1;
    idle_check("idle_after_abort", 12 * CPB);

    fork
      drive_stream();
      monitor_stream();
    join
    idle_check("idle_after_stream", 2 * CPB);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
